// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
// State encoding is common to the up and down counters.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/n_bit_up_counter.sv
// N-bit up counter with start/stop, preset load,
// captured terminal count and optional auto-reload.
module n_bit_up_counter
    import counter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         load_en,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] limit,
    input  logic         auto_reload,
    output logic [N-1:0] count_out,
    output logic         done,
    output logic         busy
);

    state_t       state;
    logic [N-1:0] limit_q;

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count_out <= '0;
            limit_q   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        limit_q <= limit;
                    end else if (load_en) begin
                        count_out <= load_val;
                    end
                end
                RUN: begin
                    // stop outranks the terminal compare
                    if (stop) begin
                        state <= IDLE;
                    end else if (count_out == limit_q) begin
                        count_out <= '0;
                        done      <= 1'b1;
                        if (!auto_reload) begin
                            state <= IDLE;
                        end
                    end else begin
                        count_out <= count_out + N'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n_bit_up_counter.sv
// Directed bench for n_bit_up_counter (N=3) with
// an expectation queue checked after each clock edge.
module tb_n_bit_up_counter;

    localparam int N = 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         load_en;
    logic [N-1:0] load_val;
    logic [N-1:0] limit;
    logic         auto_reload;
    logic [N-1:0] count_out;
    logic         done;
    logic         busy;

    int checks = 0;
    int fails  = 0;

    logic [N+1:0] sb[$];

    n_bit_up_counter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .load_en    (load_en),
        .load_val   (load_val),
        .limit      (limit),
        .auto_reload(auto_reload),
        .count_out  (count_out),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [N+1:0] e);
        logic [N+1:0] obs;
        obs = {count_out, done, busy};
        checks++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: count/done/busy got %0d/%0b/%0b want %0d/%0b/%0b",
                   tag, obs[N+1:2], obs[1], obs[0], e[N+1:2], e[1], e[0]);
        end
    endtask

    task automatic now(input string tag, input logic [N-1:0] c,
                       input logic d, input logic b);
        compare(tag, {c, d, b});
    endtask

    task automatic tick(input string tag, input logic [N-1:0] c,
                        input logic d, input logic b);
        logic [N+1:0] e;
        sb.push_back({c, d, b});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(tag, e);
    endtask

    initial begin
        rst = 1'b1;
        start = 0; stop = 0; load_en = 0;
        load_val = '0; limit = '0; auto_reload = 0;
        #3;
        now("reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        tick("idle", 0, 0, 0);

        // one-shot to limit 5
        limit = 5; auto_reload = 0; start = 1;
        tick("os_start", 0, 0, 1);
        start = 0;
        tick("os_1", 1, 0, 1);
        tick("os_2", 2, 0, 1);
        tick("os_3", 3, 0, 1);
        tick("os_4", 4, 0, 1);
        tick("os_5", 5, 0, 1);
        tick("os_term", 0, 1, 0);
        tick("os_after", 0, 0, 0);

        // auto-reload to limit 2
        limit = 2; auto_reload = 1; start = 1;
        tick("ar_start", 0, 0, 1);
        start = 0;
        tick("ar_1", 1, 0, 1);
        tick("ar_2", 2, 0, 1);
        tick("ar_term1", 0, 1, 1);
        tick("ar_1b", 1, 0, 1);
        tick("ar_2b", 2, 0, 1);
        tick("ar_term2", 0, 1, 1);
        stop = 1;
        tick("ar_stop", 0, 0, 0);
        stop = 0; auto_reload = 0;

        // preset then wrap through all-ones
        load_en = 1; load_val = 6;
        tick("ld_6", 6, 0, 0);
        load_en = 0; limit = 1; start = 1;
        tick("ld_start", 6, 0, 1);
        start = 0;
        tick("ld_7", 7, 0, 1);
        tick("ld_wrap", 0, 0, 1);
        tick("ld_1", 1, 0, 1);
        tick("ld_term", 0, 1, 0);
        tick("ld_after", 0, 0, 0);

        // start beats load; load/limit ignored in RUN
        load_en = 1; load_val = 2; limit = 7; start = 1;
        tick("sl_start", 0, 0, 1);
        start = 0; limit = 1;
        tick("sl_1", 1, 0, 1);
        tick("sl_2", 2, 0, 1);
        tick("sl_3", 3, 0, 1);
        load_en = 0; stop = 1;
        tick("pause_3", 3, 0, 0);
        stop = 0;
        tick("pause_hold", 3, 0, 0);
        limit = 7; start = 1;
        tick("resume", 3, 0, 1);
        start = 0;
        tick("resume_4", 4, 0, 1);
        tick("resume_5", 5, 0, 1);
        stop = 1;
        tick("stop_5", 5, 0, 0);
        stop = 0;

        // stop coincident with terminal count
        load_en = 1; load_val = 0;
        tick("clr", 0, 0, 0);
        load_en = 0; limit = 4; start = 1;
        tick("st_start", 0, 0, 1);
        start = 0;
        tick("st_1", 1, 0, 1);
        tick("st_2", 2, 0, 1);
        tick("st_3", 3, 0, 1);
        tick("st_4", 4, 0, 1);
        stop = 1;
        tick("st_stop", 4, 0, 0);
        stop = 0; start = 1;
        tick("st_restart", 4, 0, 1);
        start = 0;
        tick("st_term", 0, 1, 0);
        tick("st_after", 0, 0, 0);

        // async reset mid-RUN
        limit = 6; start = 1;
        tick("rr_start", 0, 0, 1);
        start = 0;
        tick("rr_1", 1, 0, 1);
        tick("rr_2", 2, 0, 1);
        tick("rr_3", 3, 0, 1);
        tick("rr_4", 4, 0, 1);
        #2 rst = 1'b1;
        #1 now("async_rst", 0, 0, 0);
        #1 rst = 1'b0;
        tick("rr_idle", 0, 0, 0);

        // limit 0 with auto-reload
        limit = 0; auto_reload = 1; start = 1;
        tick("z_start", 0, 0, 1);
        start = 0;
        tick("z_1", 0, 1, 1);
        tick("z_2", 0, 1, 1);
        stop = 1;
        tick("z_stop", 0, 0, 0);
        stop = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
